// File: rtl/can_pkg.sv
// Shared CAN bit-level definitions: FSM state encoding and default run length.
package can_pkg;

  // Number of equal consecutive bits after which a stuff bit is inserted.
  localparam int unsigned RUN_LEN_DEF = 5;

  // Destuffer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2,
    ERR   = 2'd3
  } destuff_state_t;

endpackage

// File: rtl/can_run_cnt.sv
// Run-length tracker: remembers the last bit and how many equal bits in a row
// have been seen. Shared between the destuffer and the stuffing transmitter.
module can_run_cnt
  import can_pkg::*;
#(
  parameter int unsigned RUN_LEN = RUN_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,       // drop the run: run=0, last_bit=recessive
  input  logic restart,   // start a new run with din (run=1)
  input  logic advance,   // extend the run if din matches, else restart it
  input  logic din,
  output logic same,      // din equals the remembered last bit
  output logic hit        // run after this cycle's update equals RUN_LEN
);

  localparam int unsigned RW = $clog2(RUN_LEN + 1);

  logic          last_bit, last_bit_nx;
  logic [RW-1:0] run, run_nx;

  assign same = (din == last_bit);
  assign hit  = (run_nx == RW'(RUN_LEN));

  // Next run/last_bit; run saturates at RUN_LEN so it can never wrap.
  always_comb begin
    run_nx      = run;
    last_bit_nx = last_bit;
    if (clr) begin
      run_nx      = '0;
      last_bit_nx = 1'b1;
    end else if (restart) begin
      run_nx      = RW'(1);
      last_bit_nx = din;
    end else if (advance) begin
      if (same) begin
        if (run != RW'(RUN_LEN)) run_nx = run + RW'(1);
      end else begin
        run_nx      = RW'(1);
        last_bit_nx = din;
      end
    end
  end

  // Run state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= '0;
      last_bit <= 1'b1;
    end else begin
      run      <= run_nx;
      last_bit <= last_bit_nx;
    end
  end

endmodule

// File: rtl/can_bit_destuff.sv
// CAN bit destuffer: removes the complementary bit inserted after every
// RUN_LEN equal bits, counts removed stuff bits and flags stuff violations.
module can_bit_destuff
  import can_pkg::*;
#(
  parameter int unsigned RUN_LEN = RUN_LEN_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             din_valid,
  output logic             dout,
  output logic             dout_valid,
  output logic             stuff_err,
  output logic [CNT_W-1:0] stuff_cnt
);

  destuff_state_t state, state_nx;

  logic acc;
  logic fwd, set_err, inc_cnt;
  logic rc_clr, rc_restart, rc_advance;
  logic same, hit;

  assign acc = en & din_valid;

  can_run_cnt #(
    .RUN_LEN (RUN_LEN)
  ) u_run (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rc_clr),
    .restart (rc_restart),
    .advance (rc_advance),
    .din     (din),
    .same    (same),
    .hit     (hit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and per-cycle control; en=0 overrides any accepted bit.
  always_comb begin
    state_nx   = state;
    fwd        = 1'b0;
    set_err    = 1'b0;
    inc_cnt    = 1'b0;
    rc_clr     = 1'b0;
    rc_restart = 1'b0;
    rc_advance = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      rc_clr   = 1'b1;
    end else if (acc) begin
      unique case (state)
        IDLE: begin
          fwd        = 1'b1;
          rc_restart = 1'b1;
          state_nx   = RUN;
        end
        RUN: begin
          fwd        = 1'b1;
          rc_advance = 1'b1;
          if (hit) state_nx = STUFF;
        end
        STUFF: begin
          if (same) begin
            set_err  = 1'b1;
            state_nx = ERR;
          end else begin
            rc_restart = 1'b1;
            inc_cnt    = 1'b1;
            state_nx   = RUN;
          end
        end
        ERR: state_nx = ERR;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Registered outputs; dout holds its value between forwarded bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= 1'b1;
      dout_valid <= 1'b0;
      stuff_err  <= 1'b0;
      stuff_cnt  <= '0;
    end else if (!en) begin
      dout_valid <= 1'b0;
      stuff_err  <= 1'b0;
      stuff_cnt  <= '0;
    end else begin
      dout_valid <= fwd;
      if (fwd) dout <= din;
      if (set_err) stuff_err <= 1'b1;
      if (inc_cnt && (stuff_cnt != '1)) stuff_cnt <= stuff_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_can_bit_destuff.sv
// Directed, table-driven bench for can_bit_destuff (RUN_LEN=5, CNT_W=8).
module tb_can_bit_destuff;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       din_valid;
  logic       dout;
  logic       dout_valid;
  logic       stuff_err;
  logic [7:0] stuff_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       dv;
    logic       din;
    logic       edv;
    logic       edout;
    logic       eerr;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  can_bit_destuff #(
    .RUN_LEN (5),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .stuff_err  (stuff_err),
    .stuff_cnt  (stuff_cnt)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic e, v, d, edv, edout, eerr, input logic [7:0] ecnt);
    vec_t r;
    r.en = e; r.dv = v; r.din = d;
    r.edv = edv; r.edout = edout; r.eerr = eerr; r.ecnt = ecnt;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input logic edv, edout, eerr, input logic [7:0] ecnt);
    checks++;
    if ({dout_valid, dout, stuff_err, stuff_cnt} !== {edv, edout, eerr, ecnt}) begin
      failures++;
      $display("FAIL %s: got dv=%b dout=%b err=%b cnt=%0d, want dv=%b dout=%b err=%b cnt=%0d",
               name, dout_valid, dout, stuff_err, stuff_cnt, edv, edout, eerr, ecnt);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled likewise.
  task automatic step(input logic e, v, d);
    en = e; din_valid = v; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t a[$];
    logic b;
    en = 1'b0; din = 1'b1; din_valid = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset_state", 1'b0, 1'b1, 1'b0, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // A: 0,0,0,0,0,1(stuff),1,0 -> 0,0,0,0,0,1,0 ; cnt=1
    add(1,1,0, 1,0,0,0); add(1,1,0, 1,0,0,0); add(1,1,0, 1,0,0,0);
    add(1,1,0, 1,0,0,0); add(1,1,0, 1,0,0,0);
    add(1,1,1, 0,0,0,1);
    add(1,1,1, 1,1,0,1); add(1,1,0, 1,0,0,1);
    for (int unsigned i = 0; i < tbl.size(); i++) a.push_back(tbl[i]);
    add(0,1,0, 0,0,0,0);   // en=0 wins over a simultaneous din_valid

    // B: six 1s -> five forwarded, error on the 6th, then silence while in ERR
    for (int unsigned i = 0; i < 5; i++) add(1,1,1, 1,1,0,0);
    add(1,1,1, 0,1,1,0);
    add(1,1,1, 0,1,1,0); add(1,1,0, 0,1,1,0); add(1,0,0, 0,1,1,0);
    // en=0 one cycle, then 1,0 forwarded with clean flags
    add(0,0,0, 0,1,0,0);
    add(1,1,1, 1,1,0,0); add(1,1,0, 1,0,0,0);
    add(0,1,1, 0,0,0,0);

    // C: 0x5, 1(stuff), 1x4, 0(stuff) -> 0x5,1x4 ; cnt=2
    for (int unsigned i = 0; i < 5; i++) add(1,1,0, 1,0,0,0);
    add(1,1,1, 0,0,0,1);
    for (int unsigned i = 0; i < 4; i++) add(1,1,1, 1,1,0,1);
    add(1,1,0, 0,1,0,2);
    add(0,1,0, 0,1,0,0);

    // D: scenario A with 0..3 idle cycles before each bit; dout held in gaps
    for (int unsigned i = 0; i < a.size(); i++) begin
      logic pd, pe;
      logic [7:0] pc;
      if (i == 0) begin pd = 1'b1; pe = 1'b0; pc = 8'd0; end
      else begin pd = a[i-1].edout; pe = a[i-1].eerr; pc = a[i-1].ecnt; end
      for (int unsigned k = 0; k < i % 4; k++) add(1,0,~pd, 0,pd,pe,pc);
      tbl.push_back(a[i]);
    end
    add(0,0,0, 0,0,0,0);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].dv, tbl[i].din);
      chk($sformatf("vec%0d", i), tbl[i].edv, tbl[i].edout, tbl[i].eerr, tbl[i].ecnt);
    end

    // E: reset mid-frame after three accepted 0s discards the partial run
    for (int unsigned i = 0; i < 3; i++) begin
      step(1,1,0);
      chk("pre_reset", 1'b1, 1'b0, 1'b0, 8'd0);
    end
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 1'b0, 1'b1, 1'b0, 8'd0);
    en = 1'b1; din_valid = 1'b1; din = 1'b0;
    @(posedge clk); #1;
    chk("held_in_reset", 1'b0, 1'b1, 1'b0, 8'd0);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      step(1,1,0);
      chk($sformatf("post_reset_bit%0d", i), 1'b1, 1'b0, 1'b0, 8'd0);
    end
    step(1,1,0);
    chk("post_reset_violation", 1'b0, 1'b0, 1'b1, 8'd0);
    step(0,0,0);
    chk("post_reset_clear", 1'b0, 1'b0, 1'b0, 8'd0);

    // F: stuff_cnt saturates at 255 after 260 removed stuff bits
    for (int unsigned i = 0; i < 5; i++) step(1,1,0);
    b = 1'b0;
    for (int unsigned s = 0; s < 260; s++) begin
      b = ~b;
      step(1,1,b);
      for (int unsigned i = 0; i < 4; i++) step(1,1,b);
    end
    chk("cnt_saturate", 1'b1, b, 1'b0, 8'd255);
    step(0,0,0);
    chk("cnt_clear", 1'b0, b, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
